// File: rtl/lm75_pkg.sv
// Shared encodings for the LM75 poll controller: I2C master command codes,
// LM75 register pointers and the transaction sequencer state enum.
package lm75_pkg;

  typedef enum logic [2:0] {
    CMD_START   = 3'd0,
    CMD_WR      = 3'd1,
    CMD_RD_ACK  = 3'd2,
    CMD_RD_NACK = 3'd3,
    CMD_STOP    = 3'd4
  } i2c_cmd_e;

  localparam logic [7:0] PTR_TEMP  = 8'd0;
  localparam logic [7:0] PTR_CONF  = 8'd1;
  localparam logic [7:0] PTR_THYST = 8'd2;
  localparam logic [7:0] PTR_TOS   = 8'd3;

  typedef enum logic [3:0] {
    S_IDLE,
    S_START,
    S_ADDR_W,
    S_PTR,
    S_RSTART,
    S_ADDR_R,
    S_RD_MSB,
    S_RD_LSB,
    S_WD_HI,
    S_WD_LO,
    S_STOP,
    S_ERR_STOP
  } state_e;

endpackage

// File: rtl/lm75_poll_timer.sv
// Free-running poll interval timer; raises poll_pend on each wrap and holds it
// until the sequencer launches a poll (clr). At most one poll is ever queued.
module lm75_poll_timer #(
  parameter int unsigned POLL_CYC = 500_000_000
) (
  input  logic CLK,
  input  logic rst_n,
  input  logic clr,
  output logic poll_pend
);

  logic [31:0] cnt;
  logic        wrap;

  assign wrap = (cnt == POLL_CYC - 1);

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      poll_pend <= 1'b1;
    end else begin
      cnt <= wrap ? '0 : cnt + 32'd1;
      if (wrap)
        poll_pend <= 1'b1;
      else if (clr)
        poll_pend <= 1'b0;
    end
  end

endmodule

// File: rtl/lm75_poll_ctrl.sv
// LM75 transaction sequencer: periodic temperature poll arbitrated against host
// config writes, driving a byte-level I2C master. Define LM75_AVG_EN to publish
// a 4-sample running mean instead of the raw reading.
module lm75_poll_ctrl
  import lm75_pkg::*;
#(
  parameter int unsigned POLL_CYC    = 500_000_000,
  parameter logic [6:0]  DEV_ADDR    = 7'h48,
  parameter int unsigned TIMEOUT_CYC = 1_000_000
) (
  input  logic        CLK,
  input  logic        rst_n,
  output logic [2:0]  i2c_cmd,
  output logic [7:0]  i2c_wdata,
  output logic        i2c_cmd_valid,
  input  logic        i2c_cmd_ready,
  input  logic        i2c_done,
  input  logic [7:0]  i2c_rdata,
  input  logic        i2c_nack,
  input  logic        cfg_req,
  input  logic [1:0]  cfg_ptr,
  input  logic [15:0] cfg_wdata,
  output logic        cfg_ack,
  output logic [8:0]  temp_data,
  output logic        temp_valid,
  output logic        busy,
  output logic        err_nack,
  output logic        err_timeout
);

  state_e      state, state_n, nxt;
  i2c_cmd_e    cmd;
  logic        wait_done, wait_n;
  logic        poll_pend, last_cfg, is_cfg;
  logic [1:0]  ptr_q;
  logic [15:0] wdata_q;
  logic [7:0]  msb_q;
  logic [31:0] wd;
  logic        adv, tmo, is_wr, valid;
  logic        grant_poll, grant_cfg, grant_bad, nack_hit, end_ok, end_err;
  logic [8:0]  sample, new_temp;
  logic        unused_rdata;

  assign unused_rdata = ^i2c_rdata[6:0];
  assign sample       = {msb_q, i2c_rdata[7]};

  lm75_poll_timer #(.POLL_CYC(POLL_CYC)) u_timer (
    .CLK       (CLK),
    .rst_n     (rst_n),
    .clr       (grant_poll),
    .poll_pend (poll_pend)
  );

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      wait_done <= 1'b0;
    end else begin
      state     <= state_n;
      wait_done <= wait_n;
    end
  end

  always_comb begin
    state_n    = state;
    wait_n     = wait_done;
    nxt        = S_IDLE;
    cmd        = CMD_START;
    i2c_wdata  = '0;
    is_wr      = 1'b0;
    valid      = 1'b0;
    grant_poll = 1'b0;
    grant_cfg  = 1'b0;
    grant_bad  = 1'b0;
    nack_hit   = 1'b0;
    end_ok     = 1'b0;
    end_err    = 1'b0;
    adv        = wait_done && i2c_done;
    tmo        = (state != S_IDLE) && !adv && (wd == TIMEOUT_CYC - 1);
    case (state)
      S_IDLE: begin
        // The ack cycle is skipped so a host still holding cfg_req is not re-granted.
        if (!cfg_ack) begin
          if (cfg_req && !(last_cfg && poll_pend)) begin
            if (cfg_ptr == 2'd0) grant_bad = 1'b1;
            else begin
              grant_cfg = 1'b1;
              state_n   = S_START;
            end
          end else if (poll_pend) begin
            grant_poll = 1'b1;
            state_n    = S_START;
          end
        end
      end
      S_START:  nxt = S_ADDR_W;
      S_ADDR_W: begin cmd = CMD_WR; is_wr = 1'b1; i2c_wdata = {DEV_ADDR, 1'b0}; nxt = S_PTR; end
      S_PTR: begin
        cmd       = CMD_WR;
        is_wr     = 1'b1;
        i2c_wdata = is_cfg ? {6'd0, ptr_q} : PTR_TEMP;
        if (!is_cfg)                  nxt = S_RSTART;
        else if (ptr_q == PTR_CONF[1:0]) nxt = S_WD_LO;
        else                          nxt = S_WD_HI;
      end
      S_RSTART: nxt = S_ADDR_R;
      S_ADDR_R: begin cmd = CMD_WR; is_wr = 1'b1; i2c_wdata = {DEV_ADDR, 1'b1}; nxt = S_RD_MSB; end
      S_RD_MSB: begin cmd = CMD_RD_ACK;  nxt = S_RD_LSB; end
      S_RD_LSB: begin cmd = CMD_RD_NACK; nxt = S_STOP; end
      S_WD_HI:  begin cmd = CMD_WR; is_wr = 1'b1; i2c_wdata = wdata_q[15:8]; nxt = S_WD_LO; end
      S_WD_LO:  begin cmd = CMD_WR; is_wr = 1'b1; i2c_wdata = wdata_q[7:0];  nxt = S_STOP; end
      S_STOP, S_ERR_STOP: begin cmd = CMD_STOP; nxt = S_IDLE; end
      default: state_n = S_IDLE;
    endcase
    if (state != S_IDLE) begin
      valid = !wait_done && !tmo;
      if (valid && i2c_cmd_ready) wait_n = 1'b1;
      if (adv) begin
        wait_n = 1'b0;
        if (is_wr && i2c_nack) begin
          state_n  = S_ERR_STOP;
          nack_hit = 1'b1;
        end else begin
          state_n = nxt;
          end_ok  = (state == S_STOP);
          end_err = (state == S_ERR_STOP);
        end
      end
      if (tmo) begin
        state_n = S_IDLE;
        wait_n  = 1'b0;
      end
    end
  end

  assign i2c_cmd       = cmd;
  assign i2c_cmd_valid = valid;
  assign busy          = (state != S_IDLE);

`ifdef LM75_AVG_EN
  logic [8:0]  hist0, hist1, hist2;
  logic        primed;
  logic [10:0] sum;

  // Until primed, the sum is the sample times four so the mean equals the raw reading.
  assign sum = primed ? ({{2{sample[8]}}, sample} + {{2{hist0[8]}}, hist0} +
                         {{2{hist1[8]}}, hist1} + {{2{hist2[8]}}, hist2})
                      : {sample, 2'b00};
  assign new_temp = sum[10:2];

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      hist0  <= '0;
      hist1  <= '0;
      hist2  <= '0;
      primed <= 1'b0;
    end else if (state == S_RD_LSB && adv) begin
      primed <= 1'b1;
      hist0  <= sample;
      hist1  <= primed ? hist0 : sample;
      hist2  <= primed ? hist1 : sample;
    end
  end
`else
  assign new_temp = sample;
`endif

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      wd          <= '0;
      last_cfg    <= 1'b0;
      is_cfg      <= 1'b0;
      ptr_q       <= '0;
      wdata_q     <= '0;
      msb_q       <= '0;
      cfg_ack     <= 1'b0;
      temp_data   <= '0;
      temp_valid  <= 1'b0;
      err_nack    <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      cfg_ack    <= 1'b0;
      temp_valid <= 1'b0;
      wd <= (state == S_IDLE || i2c_done || tmo) ? '0 : wd + 32'd1;
      if (grant_poll) begin
        is_cfg   <= 1'b0;
        last_cfg <= 1'b0;
      end
      if (grant_cfg) begin
        is_cfg   <= 1'b1;
        last_cfg <= 1'b1;
        ptr_q    <= cfg_ptr;
        wdata_q  <= cfg_wdata;
      end
      if (grant_bad) begin
        last_cfg <= 1'b1;
        cfg_ack  <= 1'b1;
        err_nack <= 1'b1;
      end
      if (nack_hit) err_nack <= 1'b1;
      if (end_ok) begin
        err_nack    <= 1'b0;
        err_timeout <= 1'b0;
      end
      if (tmo) err_timeout <= 1'b1;
      if ((end_ok || end_err || tmo) && is_cfg) cfg_ack <= 1'b1;
      if (state == S_RD_MSB && adv) msb_q <= i2c_rdata;
      if (state == S_RD_LSB && adv) begin
        temp_valid <= 1'b1;
        temp_data  <= new_temp;
      end
    end
  end

endmodule

// File: tb/tb_lm75_poll_ctrl.sv
// Directed bench for lm75_poll_ctrl with a reactive I2C master/slave model.
// Expectations for the LM75_AVG_EN build are selected with the same macro.
module tb_lm75_poll_ctrl;

  logic        CLK = 1'b0;
  logic        rst_n = 1'b0;
  logic [2:0]  i2c_cmd;
  logic [7:0]  i2c_wdata;
  logic        i2c_cmd_valid;
  logic        i2c_cmd_ready = 1'b1;
  logic        i2c_done = 1'b0;
  logic [7:0]  i2c_rdata = 8'h00;
  logic        i2c_nack = 1'b0;
  logic        cfg_req = 1'b0;
  logic [1:0]  cfg_ptr = 2'd0;
  logic [15:0] cfg_wdata = 16'h0000;
  logic        cfg_ack;
  logic [8:0]  temp_data;
  logic        temp_valid;
  logic        busy;
  logic        err_nack;
  logic        err_timeout;

  lm75_poll_ctrl #(.POLL_CYC(40), .DEV_ADDR(7'h48), .TIMEOUT_CYC(64)) dut (
    .CLK(CLK), .rst_n(rst_n),
    .i2c_cmd(i2c_cmd), .i2c_wdata(i2c_wdata), .i2c_cmd_valid(i2c_cmd_valid),
    .i2c_cmd_ready(i2c_cmd_ready), .i2c_done(i2c_done), .i2c_rdata(i2c_rdata),
    .i2c_nack(i2c_nack), .cfg_req(cfg_req), .cfg_ptr(cfg_ptr), .cfg_wdata(cfg_wdata),
    .cfg_ack(cfg_ack), .temp_data(temp_data), .temp_valid(temp_valid), .busy(busy),
    .err_nack(err_nack), .err_timeout(err_timeout)
  );

  always #5 CLK = ~CLK;

  int unsigned cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int total = 0;
  int bad = 0;

  // Bus model knobs and observation logs
  int          lat = 1;
  bit          stall_en = 0, silent = 0, nack_addr = 0;
  logic [7:0]  rd_msb = 8'h19, rd_lsb = 8'h80;
  logic [2:0]  logc[$];
  logic [7:0]  logd[$];
  bit          evc[$];
  int          cnt_s = 0;
  bit          pend_s = 0, resp_n = 0, resp_stop = 0;
  logic [7:0]  resp_d = 8'h00;
  int unsigned stop_done_cyc = 0;

  always @(negedge CLK) begin
    i2c_done = 1'b0;
    i2c_nack = 1'b0;
    if (!rst_n) pend_s = 0;
    i2c_cmd_ready = stall_en ? (cyc % 3 == 0) : 1'b1;
    if (pend_s) begin
      if (cnt_s == 0) begin
        i2c_done  = 1'b1;
        i2c_rdata = resp_d;
        i2c_nack  = resp_n;
        pend_s    = 0;
        if (resp_stop) stop_done_cyc = cyc;
      end else cnt_s--;
    end else if (rst_n && i2c_cmd_valid && i2c_cmd_ready) begin
      logc.push_back(i2c_cmd);
      logd.push_back(i2c_wdata);
      if (!silent) begin
        pend_s    = 1;
        cnt_s     = lat - 1;
        resp_n    = nack_addr && i2c_cmd == 3'd1 && (i2c_wdata == 8'h90 || i2c_wdata == 8'h91);
        resp_d    = (i2c_cmd == 3'd2) ? rd_msb : rd_lsb;
        resp_stop = (i2c_cmd == 3'd4);
      end
    end
  end

  always @(negedge CLK) begin
    if (cfg_ack) evc.push_back(1'b1);
    if (temp_valid) evc.push_back(1'b0);
  end

  function automatic logic sigsel(input int sel);
    case (sel)
      0: return busy;
      1: return temp_valid;
      2: return cfg_ack;
      3: return err_nack;
      default: return err_timeout;
    endcase
  endfunction

  task automatic wait_for(input int sel, input logic val, input int budget, output bit ok);
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge CLK); #1;
      if (sigsel(sel) === val) begin
        ok = 1;
        return;
      end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(negedge CLK);
    #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b required 0", busy); end
    total++; if (i2c_cmd_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b required 0", i2c_cmd_valid); end
    total++; if (temp_data !== 9'h000) begin bad++; $display("FAIL reset_temp: got %h required 000", temp_data); end
    total++; if ({cfg_ack, temp_valid, err_nack, err_timeout} !== 4'b0000) begin
      bad++; $display("FAIL reset_flags: got %b required 0000", {cfg_ack, temp_valid, err_nack, err_timeout});
    end
  endtask

  task automatic test_first_poll;
    bit ok;
    logic [2:0] ec [8];
    logic [7:0] ed [8];
    ec = '{3'd0, 3'd1, 3'd1, 3'd0, 3'd1, 3'd2, 3'd3, 3'd4};
    ed = '{8'h00, 8'h90, 8'h00, 8'h00, 8'h91, 8'h00, 8'h00, 8'h00};
    logc.delete(); logd.delete();
    rst_n = 1'b1;
    wait_for(1, 1'b1, 300, ok);
    total++; if (!ok) begin bad++; $display("FAIL first_poll_wait: temp_valid not seen, required within 300 cycles"); end
    total++; if (temp_data !== 9'h033) begin bad++; $display("FAIL first_poll_temp: got %h required 033", temp_data); end
    @(negedge CLK); #1;
    total++; if (temp_valid !== 1'b0) begin bad++; $display("FAIL first_poll_single_valid: got %b required 0", temp_valid); end
    wait_for(0, 1'b0, 100, ok);
    for (int i = 0; i < 8; i++) begin
      total++;
      if (i >= logc.size() || logc[i] !== ec[i] || (ec[i] == 3'd1 && logd[i] !== ed[i])) begin
        bad++;
        $display("FAIL poll_seq[%0d]: got cmd=%0d data=%h required cmd=%0d data=%h",
                 i, (i < logc.size()) ? logc[i] : 3'd7, (i < logd.size()) ? logd[i] : 8'hxx, ec[i], ed[i]);
      end
    end
  endtask

  task automatic test_cfg_write;
    bit ok;
    int unsigned ack_cyc;
    logic [2:0] ec [6];
    logic [7:0] ed [6];
    ec = '{3'd0, 3'd1, 3'd1, 3'd1, 3'd1, 3'd4};
    ed = '{8'h00, 8'h90, 8'h03, 8'h50, 8'h00, 8'h00};
    wait_for(0, 1'b0, 200, ok);
    stall_en = 1;
    logc.delete(); logd.delete();
    cfg_ptr = 2'd3; cfg_wdata = 16'h5000; cfg_req = 1'b1;
    wait_for(2, 1'b1, 400, ok);
    ack_cyc = cyc;
    cfg_req = 1'b0;
    total++; if (!ok) begin bad++; $display("FAIL cfg_ack_wait: cfg_ack not seen, required within 400 cycles"); end
    total++; if (ack_cyc !== stop_done_cyc + 1) begin
      bad++; $display("FAIL cfg_ack_timing: ack at cycle %0d, required %0d", ack_cyc, stop_done_cyc + 1);
    end
    total++; if (err_nack !== 1'b0) begin bad++; $display("FAIL cfg_err_nack: got %b required 0", err_nack); end
    for (int i = 0; i < 6; i++) begin
      total++;
      if (i >= logc.size() || logc[i] !== ec[i] || (ec[i] == 3'd1 && logd[i] !== ed[i])) begin
        bad++;
        $display("FAIL cfg_seq[%0d]: got cmd=%0d data=%h required cmd=%0d data=%h",
                 i, (i < logc.size()) ? logc[i] : 3'd7, (i < logd.size()) ? logd[i] : 8'hxx, ec[i], ed[i]);
      end
    end
    @(negedge CLK); #1;
    total++; if (cfg_ack !== 1'b0) begin bad++; $display("FAIL cfg_ack_pulse: got %b required 0", cfg_ack); end
    stall_en = 0;
  endtask

  task automatic test_bad_ptr;
    bit ok;
    int unsigned req_cyc;
    wait_for(1, 1'b1, 300, ok);
    wait_for(0, 1'b0, 100, ok);
    logc.delete(); logd.delete();
    req_cyc = cyc;
    cfg_ptr = 2'd0; cfg_req = 1'b1;
    wait_for(2, 1'b1, 10, ok);
    cfg_req = 1'b0;
    total++; if (!ok || cyc !== req_cyc + 1) begin
      bad++; $display("FAIL bad_ptr_ack: ack at cycle %0d (seen=%b), required %0d", cyc, ok, req_cyc + 1);
    end
    total++; if (err_nack !== 1'b1 || busy !== 1'b0 || logc.size() != 0) begin
      bad++; $display("FAIL bad_ptr_state: err_nack=%b busy=%b cmds=%0d required 1,0,0", err_nack, busy, logc.size());
    end
    wait_for(1, 1'b1, 300, ok);
    wait_for(0, 1'b0, 100, ok);
    total++; if (err_nack !== 1'b0) begin bad++; $display("FAIL bad_ptr_clear: err_nack got %b required 0", err_nack); end
  endtask

  task automatic test_back_to_back;
    bit ok;
    lat = 8;
    wait_for(0, 1'b0, 200, ok);
    evc.delete();
    cfg_ptr = 2'd1; cfg_wdata = 16'h00A5; cfg_req = 1'b1;
    for (int i = 0; i < 1500 && evc.size() < 4; i++) begin
      @(negedge CLK); #1;
    end
    cfg_req = 1'b0;
    for (int i = 0; i < 4; i++) begin
      total++;
      if (i >= evc.size() || evc[i] !== ((i % 2) == 0)) begin
        bad++; $display("FAIL alternate[%0d]: got %s required %s", i,
                        (i >= evc.size()) ? "none" : (evc[i] ? "cfg" : "poll"), ((i % 2) == 0) ? "cfg" : "poll");
      end
    end
    lat = 1;
  endtask

  task automatic test_nack;
    bit ok;
    wait_for(0, 1'b0, 300, ok);
    nack_addr = 1;
    logc.delete(); logd.delete(); evc.delete();
    wait_for(3, 1'b1, 300, ok);
    total++; if (!ok) begin bad++; $display("FAIL nack_flag: err_nack not set, required within 300 cycles"); end
    wait_for(0, 1'b0, 100, ok);
    nack_addr = 0;
    total++; if (logc.size() < 3 || logc[0] !== 3'd0 || logc[1] !== 3'd1 || logd[1] !== 8'h90 || logc[2] !== 3'd4) begin
      bad++; $display("FAIL nack_seq: got %0d cmds first=%0d,%0d,%0d required START,WR 90,STOP",
                      logc.size(), (logc.size() > 0) ? logc[0] : 3'd7, (logc.size() > 1) ? logc[1] : 3'd7,
                      (logc.size() > 2) ? logc[2] : 3'd7);
    end
    total++; if (temp_data !== 9'h033 || evc.size() != 0) begin
      bad++; $display("FAIL nack_temp: got %h events=%0d required 033 events=0", temp_data, evc.size());
    end
    rd_msb = 8'h1A; rd_lsb = 8'h00;
    wait_for(1, 1'b1, 300, ok);
`ifdef LM75_AVG_EN
    total++; if (temp_data !== 9'h033) begin bad++; $display("FAIL nack_recover_temp: got %h required 033", temp_data); end
`else
    total++; if (temp_data !== 9'h034) begin bad++; $display("FAIL nack_recover_temp: got %h required 034", temp_data); end
`endif
    wait_for(0, 1'b0, 100, ok);
    total++; if (err_nack !== 1'b0) begin bad++; $display("FAIL nack_clear: err_nack got %b required 0", err_nack); end
  endtask

  task automatic test_timeout;
    bit ok;
    int n;
    wait_for(0, 1'b0, 300, ok);
    silent = 1;
    wait_for(0, 1'b1, 100, ok);
    n = 0;
    while (err_timeout !== 1'b1 && n < 200) begin
      @(negedge CLK); #1;
      n++;
    end
    total++; if (n != 64) begin bad++; $display("FAIL timeout_cycles: got %0d required 64", n); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL timeout_idle: busy got %b required 0", busy); end
    silent = 0;
    wait_for(1, 1'b1, 300, ok);
    wait_for(0, 1'b0, 100, ok);
    total++; if (err_timeout !== 1'b0) begin bad++; $display("FAIL timeout_clear: got %b required 0", err_timeout); end
  endtask

  task automatic test_avg_reset;
    bit ok;
    logic [7:0] msbs [4];
    logic [8:0] smp [4];
    msbs = '{8'h18, 8'h1A, 8'h1C, 8'h1E};
    smp  = '{9'h030, 9'h034, 9'h038, 9'h03C};
    for (int i = 0; i < 4; i++) begin
      wait_for(0, 1'b0, 300, ok);
      rd_msb = msbs[i]; rd_lsb = 8'h00;
      wait_for(1, 1'b1, 300, ok);
`ifndef LM75_AVG_EN
      total++; if (temp_data !== smp[i]) begin bad++; $display("FAIL raw_sample[%0d]: got %h required %h", i, temp_data, smp[i]); end
`endif
    end
`ifdef LM75_AVG_EN
    total++; if (temp_data !== 9'h036) begin bad++; $display("FAIL avg_final: got %h required 036", temp_data); end
`endif
    wait_for(0, 1'b0, 300, ok);
    logc.delete(); logd.delete();
    for (int i = 0; i < 300 && !(logc.size() > 0 && logc[logc.size()-1] == 3'd2); i++) begin
      @(negedge CLK); #1;
    end
    rst_n = 1'b0;
    #1;
    total++; if (busy !== 1'b0 || i2c_cmd_valid !== 1'b0) begin
      bad++; $display("FAIL reset_mid_read: busy=%b valid=%b required 0,0", busy, i2c_cmd_valid);
    end
    total++; if (temp_data !== 9'h000) begin bad++; $display("FAIL reset_mid_temp: got %h required 000", temp_data); end
    @(negedge CLK);
    rst_n = 1'b1;
    wait_for(1, 1'b1, 300, ok);
    total++; if (temp_data !== 9'h03C) begin bad++; $display("FAIL post_reset_temp: got %h required 03c", temp_data); end
  endtask

  initial begin
    test_reset();
    test_first_poll();
    test_cfg_write();
    test_bad_ptr();
    test_back_to_back();
    test_nack();
    test_timeout();
    test_avg_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation still running at 2 ms, required to finish earlier");
    $fatal(1, "bench time limit reached");
  end

endmodule
